// File: rtl/fp_regfile_mp.sv
// Multi-port FP register file: NRD combinational reads, fast + long-latency write ports,
// busy scoreboard with claim/release, post-reset clear sequencer, optional write-to-read bypass.
module fp_regfile_mp #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = $clog2(NREG),
  parameter int unsigned NRD    = 3,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                we0,
  input  logic [AW-1:0]       waddr0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic                claim_valid,
  input  logic [AW-1:0]       claim_addr,
  output logic                claim_ready,
  output logic                init_done,
  output logic                waw_err
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t          state_q;
  logic [AW-1:0]   clr_idx_q;
  logic            init_done_q;
  logic            waw_err_q;
  logic [NREG-1:0] busy_q, busy_d;
  logic [XLEN-1:0] regs_q [NREG];

  logic run;
  logic wr0_ok, wr0_drop, wr1_en, claim_fire;

  assign run        = (state_q == S_RUN);
  assign wr1_en     = run && we1;
  // Busy is judged on the pre-edge scoreboard, so a same-cycle release never rescues port 0.
  assign wr0_ok     = run && we0 && !busy_q[waddr0];
  assign wr0_drop   = run && we0 &&  busy_q[waddr0];
  assign claim_ready = init_done_q && (!busy_q[claim_addr] || (we1 && waddr1 == claim_addr));
  assign claim_fire = claim_valid && claim_ready;

  assign init_done = init_done_q;
  assign waw_err   = waw_err_q;

  always_comb begin
    busy_d = busy_q;
    if (wr1_en)     busy_d[waddr1]     = 1'b0;
    if (claim_fire) busy_d[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CLEAR;
      clr_idx_q   <= '0;
      init_done_q <= 1'b0;
      waw_err_q   <= 1'b0;
      busy_q      <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          waw_err_q <= 1'b0;
          clr_idx_q <= clr_idx_q + AW'(1);
          if (clr_idx_q == AW'(NREG - 1)) begin
            state_q     <= S_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: begin
          waw_err_q <= wr0_drop;
          busy_q    <= busy_d;
        end
      endcase
    end
  end

  // Array carries no reset; the clear sequencer zeroes it after every reset release.
  always_ff @(posedge clk) begin
    if (!run) begin
      regs_q[clr_idx_q] <= '0;
    end else begin
      if (wr0_ok) regs_q[waddr0] <= wdata0;
      if (wr1_en) regs_q[waddr1] <= wdata1;
    end
  end

  always_comb begin
    logic [AW-1:0] ra;
    ra    = '0;
    rdata = '0;
    rbusy = '0;
    if (run) begin
      for (int i = 0; i < NRD; i++) begin
        ra = raddr[i*AW +: AW];
        rdata[i*XLEN +: XLEN] = regs_q[ra];
        rbusy[i]              = busy_q[ra];
        if (BYPASS) begin
          if (wr1_en && waddr1 == ra) begin
            rdata[i*XLEN +: XLEN] = wdata1;
            rbusy[i]              = 1'b0;
          end else if (wr0_ok && waddr0 == ra) begin
            rdata[i*XLEN +: XLEN] = wdata0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_regfile_mp.sv
// Directed bench for fp_regfile_mp: one bypassing and one non-bypassing instance share stimulus.
module tb_fp_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   raddr;
  logic                we0, we1, claim_valid;
  logic [AW-1:0]       waddr0, waddr1, claim_addr;
  logic [XLEN-1:0]     wdata0, wdata1;

  logic [NRD*XLEN-1:0] rdata_b, rdata_n;
  logic [NRD-1:0]      rbusy_b, rbusy_n;
  logic                crdy_b, crdy_n, idone_b, idone_n, waw_b, waw_n;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .claim_valid(claim_valid), .claim_addr(claim_addr), .claim_ready(crdy_b),
    .init_done(idone_b), .waw_err(waw_b));

  fp_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .claim_valid(claim_valid), .claim_addr(claim_addr), .claim_ready(crdy_n),
    .init_done(idone_n), .waw_err(waw_n));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int p, input logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  function automatic logic [31:0] rd_b(input int p);
    return rdata_b[p*XLEN +: XLEN];
  endfunction

  function automatic logic [31:0] rd_n(input int p);
    return rdata_n[p*XLEN +: XLEN];
  endfunction

  task automatic idle_inputs();
    we0 = 0; we1 = 0; claim_valid = 0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; claim_addr = '0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Expects init_done low for exactly 32 edges after reset release, with claims refused.
  task automatic clear_check(input string tag);
    claim_valid = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      claim_addr = AW'(i);
      #1;
      chk({tag, "_idone_lo"}, idone_b, 1'b0);
      chk({tag, "_crdy_lo"}, crdy_b, 1'b0);
      step();
    end
    claim_valid = 1'b0;
    #1;
    chk({tag, "_idone_hi"}, idone_b, 1'b1);
    chk({tag, "_idone_hi_nb"}, idone_n, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < NREG; a++) begin
      for (int p = 0; p < NRD; p++) set_ra(p, AW'(a));
      #1;
      for (int p = 0; p < NRD; p++) begin
        chk({tag, "_rdata"}, rd_b(p), 32'h0);
        chk({tag, "_rbusy"}, rbusy_b[p], 1'b0);
      end
      chk({tag, "_rdata_nb"}, rd_n(0), 32'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    raddr = '0;
    idle_inputs();
    #2;
    for (int p = 0; p < NRD; p++) begin
      chk("rst_rdata", rd_b(p), 32'h0);
      chk("rst_rbusy", rbusy_b[p], 1'b0);
    end
    chk("rst_crdy", crdy_b, 1'b0);
    chk("rst_idone", idone_b, 1'b0);
    chk("rst_waw", waw_b, 1'b0);
    step();
    rst_n = 1'b1;
    clear_check("clr0");

    for (int i = 0; i < NREG; i++) begin
      we0 = 1; waddr0 = AW'(i); wdata0 = 32'hDEAD_0000 | i;
      step();
    end
    we0 = 0;
    set_ra(0, 5'd31);
    #1;
    chk("garbage_r31", rd_n(0), 32'hDEAD_001F);

    pulse_reset();
    for (int i = 0; i < 10; i++) step();
    pulse_reset();
    clear_check("clr_mid");
    check_all_zero("zero_after_clr");

    // Fast write with and without bypass
    set_ra(0, 5'd5);
    we0 = 1; waddr0 = 5'd5; wdata0 = 32'h3F80_0000;
    #1;
    chk("byp_we0", rd_b(0), 32'h3F80_0000);
    chk("nobyp_we0_old", rd_n(0), 32'h0);
    step();
    we0 = 0;
    #1;
    chk("nobyp_we0_new", rd_n(0), 32'h3F80_0000);
    chk("byp_we0_held", rd_b(0), 32'h3F80_0000);

    // Claim, release with bypass, re-claim in the release cycle
    claim_valid = 1; claim_addr = 5'd7;
    #1;
    chk("claim7_rdy", crdy_b, 1'b1);
    step();
    claim_valid = 0;
    set_ra(1, 5'd7);
    #1;
    chk("claim7_busy", rbusy_b[1], 1'b1);
    chk("claim7_busy_nb", rbusy_n[1], 1'b1);
    chk("claim7_rdy_lo", crdy_b, 1'b0);
    we1 = 1; waddr1 = 5'd7; wdata1 = 32'h4049_0FDB;
    claim_valid = 1;
    #1;
    chk("rel7_rbusy_byp", rbusy_b[1], 1'b0);
    chk("rel7_rdata_byp", rd_b(1), 32'h4049_0FDB);
    chk("rel7_rbusy_nb", rbusy_n[1], 1'b1);
    chk("rel7_reclaim_rdy", crdy_b, 1'b1);
    step();
    idle_inputs();
    #1;
    chk("rel7_busy_kept", rbusy_b[1], 1'b1);
    chk("rel7_rdata", rd_b(1), 32'h4049_0FDB);
    chk("rel7_rdata_nb", rd_n(1), 32'h4049_0FDB);

    // WAW drop on busy register 9
    claim_valid = 1; claim_addr = 5'd9;
    step();
    claim_valid = 0;
    set_ra(2, 5'd9);
    we0 = 1; waddr0 = 5'd9; wdata0 = 32'h1111_1111;
    #1;
    chk("waw_no_byp", rd_b(2), 32'h0);
    chk("waw_lo_pre", waw_b, 1'b0);
    step();
    we0 = 0;
    #1;
    chk("waw_pulse", waw_b, 1'b1);
    chk("waw_r9_kept", rd_b(2), 32'h0);
    chk("waw_r9_kept_nb", rd_n(2), 32'h0);
    step();
    chk("waw_one_cycle", waw_b, 1'b0);

    // Busy 9: port 0 still dropped even though port 1 releases it this cycle
    we0 = 1; waddr0 = 5'd9; wdata0 = 32'h2222_2222;
    we1 = 1; waddr1 = 5'd9; wdata1 = 32'h3333_3333;
    step();
    idle_inputs();
    #1;
    chk("busycol_r9", rd_n(2), 32'h3333_3333);
    chk("busycol_waw", waw_b, 1'b1);
    chk("busycol_free", rbusy_b[2], 1'b0);

    // Collision on free register 3: port 1 wins, no error
    set_ra(0, 5'd3);
    we0 = 1; waddr0 = 5'd3; wdata0 = 32'hAAAA_0000;
    we1 = 1; waddr1 = 5'd3; wdata1 = 32'h5555_FFFF;
    #1;
    chk("col_byp", rd_b(0), 32'h5555_FFFF);
    step();
    idle_inputs();
    #1;
    chk("col_r3", rd_b(0), 32'h5555_FFFF);
    chk("col_r3_nb", rd_n(0), 32'h5555_FFFF);
    chk("col_waw", waw_b, 1'b0);

    // Reset in RUN with claims outstanding
    claim_valid = 1; claim_addr = 5'd4;
    step();
    claim_addr = 5'd6;
    step();
    claim_valid = 0;
    set_ra(0, 5'd4); set_ra(1, 5'd6);
    #1;
    chk("pre_rst_busy4", rbusy_b[0], 1'b1);
    chk("pre_rst_busy6", rbusy_b[1], 1'b1);
    pulse_reset();
    clear_check("clr_run");
    check_all_zero("zero_after_run_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
